// File: rtl/fe_tobytes_pkg.sv
// Shared constants for the fe_tobytes field-element encoder and its arbiter.
// Field elements are 10 limbs of 32 bits in and 256 canonical bits out.
package fe_tobytes_pkg;

   localparam int FE_LIMB_W = 32;
   localparam int FE_LIMBS  = 10;
   localparam int FE_IN_W   = FE_LIMB_W * FE_LIMBS;
   localparam int FE_OUT_W  = 256;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;
   localparam logic [1:0] ST_RESP  = 2'd3;

endpackage

// File: rtl/fe_tobytes_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after i_ptr,
// wrapping at NUM_REQ.
module rr_pick #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [IDX_W-1:0]   i_ptr,
   output logic               o_found,
   output logic [IDX_W-1:0]   o_idx
);

   logic [IDX_W-1:0] w_cand [NUM_REQ];

   // w_cand[k] is the requester index at priority rank k (rank 0 = i_ptr).
   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
      logic [IDX_W:0] w_sum;
      logic [IDX_W:0] w_diff;
      assign w_sum  = {1'b0, i_ptr} + (IDX_W+1)'(gi);
      assign w_diff = w_sum - (IDX_W+1)'(NUM_REQ);
      assign w_cand[gi] = (w_sum >= (IDX_W+1)'(NUM_REQ)) ? w_diff[IDX_W-1:0]
                                                         : w_sum[IDX_W-1:0];
   end

   // Scan from lowest priority upward so the highest-priority hit wins last.
   always_comb begin
      o_found = 1'b0;
      o_idx   = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (i_req[w_cand[k]]) begin
            o_found = 1'b1;
            o_idx   = w_cand[k];
         end
      end
   end

endmodule

// File: rtl/fe_tobytes_arbiter.sv
// Round-robin arbiter sharing one fe_tobytes unit among NUM_REQ requesters.
// Optional done watchdog enabled by defining FE_TOBYTES_ARB_WDOG_EN.
module fe_tobytes_arbiter
   import fe_tobytes_pkg::*;
#(
   parameter int NUM_REQ     = 4,
   parameter int IDX_W       = 2,
   parameter int WDOG_CYCLES = 255
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_REQ-1:0]          req,
   input  logic [NUM_REQ*FE_IN_W-1:0]  req_in,
   output logic [NUM_REQ-1:0]          gnt,
   output logic [NUM_REQ-1:0]          resp_valid,
   output logic [FE_OUT_W-1:0]         resp_out,
   output logic                        busy,
   output logic [FE_IN_W-1:0]          fe_in,
   output logic                        fe_valid,
   input  logic [FE_OUT_W-1:0]         fe_out,
   input  logic                        fe_done,
   output logic                        err
);

   logic [1:0]            r_state;
   logic [IDX_W-1:0]      r_ptr;
   logic [IDX_W-1:0]      r_cur;
   logic [NUM_REQ-1:0]    r_gnt;
   logic [NUM_REQ-1:0]    r_resp_valid;
   logic [FE_OUT_W-1:0]   r_resp_out;
   logic [FE_IN_W-1:0]    r_fe_in;
   logic                  r_fe_valid;
   logic                  r_done_armed;

   logic                  w_found;
   logic [IDX_W-1:0]      w_idx;
   logic                  w_accept;
   logic                  w_wdog_hit;
   logic [FE_IN_W-1:0]    w_ops [NUM_REQ];
   logic [NUM_REQ-1:0]    w_one;

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ops
      assign w_ops[gi] = req_in[gi*FE_IN_W +: FE_IN_W];
   end

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_pick (
      .i_req   (req),
      .i_ptr   (r_ptr),
      .o_found (w_found),
      .o_idx   (w_idx)
   );

   assign w_one = {{(NUM_REQ-1){1'b0}}, 1'b1};

   // A done level present on entry to WAIT belongs to the previous operation;
   // it only counts once it has been seen low during this WAIT.
   assign w_accept = fe_done & r_done_armed;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state      <= ST_IDLE;
         r_ptr        <= '0;
         r_cur        <= '0;
         r_gnt        <= '0;
         r_resp_valid <= '0;
         r_resp_out   <= '0;
         r_fe_in      <= '0;
         r_fe_valid   <= 1'b0;
         r_done_armed <= 1'b0;
      end else begin
         r_gnt        <= '0;
         r_resp_valid <= '0;
         r_fe_valid   <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_found) begin
                  r_fe_in <= w_ops[w_idx];
                  r_cur   <= w_idx;
                  r_gnt   <= w_one << w_idx;
                  r_state <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               r_fe_valid   <= 1'b1;
               r_done_armed <= 1'b0;
               r_state      <= ST_WAIT;
            end
            ST_WAIT: begin
               r_done_armed <= r_done_armed | ~fe_done;
               if (w_accept) begin
                  r_resp_out <= fe_out;
                  r_state    <= ST_RESP;
               end else if (w_wdog_hit) begin
                  r_state <= ST_RESP;
               end
            end
            ST_RESP: begin
               r_resp_valid <= w_one << r_cur;
               r_ptr        <= (r_cur == IDX_W'(NUM_REQ - 1)) ? '0 : r_cur + 1'b1;
               r_state      <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

`ifdef FE_TOBYTES_ARB_WDOG_EN
   localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);

   logic [WDOG_W-1:0] r_wdog_cnt;
   logic              r_err;

   // Fires on the WDOG_CYCLES-th WAIT cycle without an accepted done.
   assign w_wdog_hit = (r_wdog_cnt == WDOG_W'(WDOG_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_wdog_cnt <= '0;
         r_err      <= 1'b0;
      end else if (r_state == ST_ISSUE) begin
         r_wdog_cnt <= '0;
      end else if (r_state == ST_WAIT && !w_accept) begin
         r_wdog_cnt <= r_wdog_cnt + 1'b1;
         if (w_wdog_hit) begin
            r_err <= 1'b1;
         end
      end
   end

   assign err = r_err;
`else
   assign w_wdog_hit = 1'b0;
   // Without the watchdog err is constant 0; the comparison is never true.
   assign err = (WDOG_CYCLES < 0);
`endif

   assign gnt        = r_gnt;
   assign resp_valid = r_resp_valid;
   assign resp_out   = r_resp_out;
   assign busy       = (r_state != ST_IDLE);
   assign fe_in      = r_fe_in;
   assign fe_valid   = r_fe_valid;

endmodule

// File: doc/fe_tobytes_arbiter.md
Name: fe_tobytes_arbiter

Overview:
Round-robin arbiter that shares one fe_tobytes instance (320-bit 10-limb field element to 256-bit canonical byte encoding) among NUM_REQ requesters, e.g. the point-compression and signature-encode stages of the ed25519 core. It latches the granted requester's operand, pulses the unit's valid, waits for done, then returns the result to that requester only. One conversion is in flight at a time.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
IDX_W, 2, index width, equal to clog2(NUM_REQ)
WDOG_CYCLES, 255, done timeout in cycles; used only when the watchdog is compiled in

Ports:
clk  input  1  system clock, all logic on the rising edge
rst  input  1  synchronous, active-low reset
req  input  NUM_REQ  per-requester request level, held until the matching resp_valid
req_in  input  NUM_REQ*320  per-requester operand; slice i is [320*i+319:320*i]
gnt  output  NUM_REQ  one-hot; a 1-cycle pulse when the operand is captured
resp_valid  output  NUM_REQ  one-hot, 1-cycle pulse; resp_out is valid in that cycle
resp_out  output  256  conversion result, held until the next result
busy  output  1  high while any state other than IDLE is active
fe_in  output  320  to fe_tobytes in; registered operand
fe_valid  output  1  to fe_tobytes valid; 1-cycle pulse
fe_out  input  256  from fe_tobytes out
fe_done  input  1  from fe_tobytes done
err  output  1  sticky watchdog error; tied to 0 when the watchdog is compiled out

Behaviour:
- Reset (rst==0 at a clock edge):
  - State goes to IDLE.
  - gnt, resp_valid, fe_valid, busy and err go to 0.
  - resp_out and fe_in go to 0.
  - Round-robin pointer goes to 0.
  - Reset mid-operation abandons the conversion with no response. fe_tobytes shares rst and is reset by it.
- IDLE:
  - If req is nonzero, pick the first set bit searching from ptr upward, wrapping at NUM_REQ.
  - Latch the slice into fe_in, store the index in cur, pulse gnt[cur], and go to ISSUE.
  - Latency from req to gnt is 1 cycle.
- ISSUE: fe_valid=1 for exactly this cycle, then go to WAIT.
- WAIT:
  - On fe_done==1, capture fe_out into resp_out and go to RESP.
  - fe_done is sampled only in WAIT. A done level already high on entry to WAIT is ignored until it has been seen low at least once, so a stale done from the previous operation is not accepted.
- RESP:
  - Pulse resp_valid[cur].
  - Set ptr to cur+1 modulo NUM_REQ, giving the served requester lowest priority next.
  - Return to IDLE.
- Minimum turnaround is 4 cycles plus the fe_tobytes latency. Back-to-back requests from different requesters are fair: with all req bits high, grants rotate 0,1,2,3,0.
- Requester rules:
  - A requester must deassert req in the cycle after its resp_valid, or it is treated as a new request.
  - req_in may change after gnt.
  - Dropping req after gnt does not cancel the operation; the response is still pulsed.
- Simultaneous events:
  - A new req arriving during WAIT is queued implicitly because req is level-sensitive.
  - A req bit for an index >= NUM_REQ cannot exist.

Optional Feature:
- Macro FE_TOBYTES_ARB_WDOG_EN.
- Defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches WDOG_CYCLES without an accepted done:
    - Set err, which stays sticky until reset.
    - Pulse resp_valid[cur] with resp_out unchanged (the previous value).
    - Go to IDLE via RESP.
- Undefined: no counter, err is tied to 0, and WAIT waits indefinitely.

Decomposition:
- Package fe_tobytes_pkg holds:
  - FE_LIMB_W=32, FE_LIMBS=10, FE_IN_W=320, FE_OUT_W=256.
  - The state enumeration IDLE/ISSUE/WAIT/RESP as 2-bit constants.
- Sub-module rr_pick (parameter NUM_REQ): combinational round-robin picker, inputs req and ptr, outputs a found flag and an index.
- The arbiter FSM, the operand and result registers, and the watchdog live in the top module.

Test Plan:
1. Single request: req=4'b0001, req_in[319:0]=320'hff348211fef50137006a7aa9014d6f3f00fe8356fe5600a000dfcc46019732a5ff5135d600c4b8ae -> gnt[0] 1 cycle later, then one fe_valid pulse, then resp_valid[0] with resp_out=256'h4d20842f50137353d54a9ade7efe83559580281bf988ccb9952544d758c4b89b.
2. Fairness: req=4'b1111 held, each requester re-asserting after its response -> grant order 0,1,2,3,0. No requester is granted twice while another is waiting.
3. Pointer wrap: after serving requester 3, req=4'b1001 -> requester 0 is granted before 3.
4. Reset mid-WAIT: rst=0 for 1 cycle during a conversion -> all outputs are 0 the next cycle, no resp_valid follows, and a new req=4'b0100 is then served normally.
5. Stale done: a model holds fe_done high across an operation boundary -> the second result is captured only after done falls and rises again.
6. With FE_TOBYTES_ARB_WDOG_EN and WDOG_CYCLES=16, a model that never raises done -> err=1 and resp_valid[cur] pulse after 16 WAIT cycles, then return to IDLE.
